// File: rtl/cdb_arbiter.sv
// cdb_arbiter: completion-stage arbiter. Buffers one result per functional unit
// and broadcasts up to three of them per cycle on a registered 3-wide common
// data bus. Optional macro CDB_RR_PRIORITY_EN selects round-robin priority;
// when undefined the scan always starts at slot 0 (fixed priority).

package cdb_pkg;
  localparam int unsigned XLEN = 32;
  localparam int unsigned PR   = 6;
  localparam logic [PR-1:0] ZERO_PR = '0;

  typedef struct packed {
    logic [PR-1:0] t0;
    logic [PR-1:0] t1;
    logic [PR-1:0] t2;
  } CDB_T_PACKET;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned N_FU = 6
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  logic [N_FU-1:0]            fu_valid,
  input  logic [N_FU-1:0][PR-1:0]    fu_tag,
  input  logic [N_FU-1:0][XLEN-1:0]  fu_data,
  output logic [N_FU-1:0]            fu_ready,
  output CDB_T_PACKET                cdb_out,
  output logic [2:0][XLEN-1:0]       wr_data,
  output logic [1:0]                 cdb_count
);

  localparam int unsigned PtrW = $clog2(N_FU);
  localparam logic [PtrW:0] NFuW = (PtrW + 1)'(N_FU);

  // Result slots
  logic [N_FU-1:0]           slot_valid_q, slot_valid_d;
  logic [N_FU-1:0][PR-1:0]   slot_tag_q, slot_tag_d;
  logic [N_FU-1:0][XLEN-1:0] slot_data_q, slot_data_d;

  // Scan start pointer
  logic [PtrW-1:0] ptr_q, ptr_d;

  // Output register
  CDB_T_PACKET          cdb_q, cdb_d;
  logic [2:0][XLEN-1:0] wr_data_q, wr_data_d;
  logic [1:0]           cnt_q, cnt_d;

  // Lane selection
  logic [N_FU-1:0]      grant;
  logic [2:0][PR-1:0]   lane_tag;
  logic [2:0][XLEN-1:0] lane_data;
  logic [1:0]           lane_cnt;
  logic [PtrW:0]        scan_sum;
  logic [PtrW-1:0]      scan_idx;
`ifdef CDB_RR_PRIORITY_EN
  logic [PtrW-1:0]      last_idx;
`endif

  // Scan slots from ptr (wrapping) and grant the first three valid ones to lanes in order
  always_comb begin
    grant     = '0;
    lane_tag  = '0;
    lane_data = '0;
    lane_cnt  = '0;
    scan_sum  = '0;
    scan_idx  = '0;
`ifdef CDB_RR_PRIORITY_EN
    last_idx  = ptr_q;
`endif
    for (int k = 0; k < N_FU; k++) begin
      scan_sum = {1'b0, ptr_q} + (PtrW + 1)'(k);
      if (scan_sum >= NFuW) scan_sum = scan_sum - NFuW;
      scan_idx = scan_sum[PtrW-1:0];
      if (slot_valid_q[scan_idx] && (lane_cnt != 2'd3)) begin
        grant[scan_idx]     = 1'b1;
        lane_tag[lane_cnt]  = slot_tag_q[scan_idx];
        lane_data[lane_cnt] = slot_data_q[scan_idx];
`ifdef CDB_RR_PRIORITY_EN
        last_idx            = scan_idx;
`endif
        lane_cnt            = lane_cnt + 2'd1;
      end
    end
  end

  // Ready depends only on registered slot state, never on fu_valid
  always_comb begin
    fu_ready = {N_FU{~reset}} & (~slot_valid_q | grant);
  end

  // Slot next state: refill wins over grant-clear; zero-tag results are swallowed
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_tag_d   = slot_tag_q;
    slot_data_d  = slot_data_q;
    for (int i = 0; i < N_FU; i++) begin
      if (fu_valid[i] && fu_ready[i]) begin
        slot_valid_d[i] = (fu_tag[i] != ZERO_PR);
        slot_tag_d[i]   = fu_tag[i];
        slot_data_d[i]  = fu_data[i];
      end else if (grant[i]) begin
        slot_valid_d[i] = 1'b0;
      end
    end
    if (squash) slot_valid_d = '0;
  end

  // Priority pointer next state; squash leaves it untouched
  always_comb begin
    ptr_d = ptr_q;
`ifdef CDB_RR_PRIORITY_EN
    if (!squash && (lane_cnt != 2'd0)) begin
      ptr_d = (last_idx == PtrW'(N_FU - 1)) ? '0 : last_idx + PtrW'(1);
    end
`else
    ptr_d = '0;
`endif
  end

  // Output register next state; squash empties every lane
  always_comb begin
    cdb_d.t0  = lane_tag[0];
    cdb_d.t1  = lane_tag[1];
    cdb_d.t2  = lane_tag[2];
    wr_data_d = lane_data;
    cnt_d     = lane_cnt;
    if (squash) begin
      cdb_d     = '{t0: ZERO_PR, t1: ZERO_PR, t2: ZERO_PR};
      wr_data_d = '0;
      cnt_d     = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid_q <= '0;
      slot_tag_q   <= '0;
      slot_data_q  <= '0;
      ptr_q        <= '0;
      cdb_q        <= '{t0: ZERO_PR, t1: ZERO_PR, t2: ZERO_PR};
      wr_data_q    <= '0;
      cnt_q        <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_tag_q   <= slot_tag_d;
      slot_data_q  <= slot_data_d;
      ptr_q        <= ptr_d;
      cdb_q        <= cdb_d;
      wr_data_q    <= wr_data_d;
      cnt_q        <= cnt_d;
    end
  end

  // Registered bus outputs
  always_comb begin
    cdb_out   = cdb_q;
    wr_data   = wr_data_q;
    cdb_count = cnt_q;
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (N_FU=6). Expected bus contents are pushed to a
// queue one per clock edge and popped/compared right after that edge.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int unsigned NFu = 6;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     squash;
  logic [NFu-1:0]           fu_valid;
  logic [NFu-1:0][PR-1:0]   fu_tag;
  logic [NFu-1:0][XLEN-1:0] fu_data;
  logic [NFu-1:0]           fu_ready;
  CDB_T_PACKET              cdb_out;
  logic [2:0][XLEN-1:0]     wr_data;
  logic [1:0]               cdb_count;

  typedef struct {
    logic [PR-1:0]   t0, t1, t2;
    logic [XLEN-1:0] d0, d1, d2;
    logic [1:0]      cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  cdb_arbiter #(.N_FU(NFu)) dut (
    .clock     (clock),
    .reset     (reset),
    .squash    (squash),
    .fu_valid  (fu_valid),
    .fu_tag    (fu_tag),
    .fu_data   (fu_data),
    .fu_ready  (fu_ready),
    .cdb_out   (cdb_out),
    .wr_data   (wr_data),
    .cdb_count (cdb_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int i, input logic [PR-1:0] t, input logic [XLEN-1:0] d);
    fu_valid[i] = 1'b1;
    fu_tag[i]   = t;
    fu_data[i]  = d;
  endtask

  task automatic drop(input int i);
    fu_valid[i] = 1'b0;
    fu_tag[i]   = '0;
    fu_data[i]  = '0;
  endtask

  task automatic push_exp(input logic [PR-1:0] t0, input logic [PR-1:0] t1,
                          input logic [PR-1:0] t2, input logic [XLEN-1:0] d0,
                          input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                          input logic [1:0] cnt);
    exp_t e;
    e.t0 = t0; e.t1 = t1; e.t2 = t2;
    e.d0 = d0; e.d1 = d1; e.d2 = d2;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic push_idle();
    push_exp(ZERO_PR, ZERO_PR, ZERO_PR, '0, '0, '0, 2'd0);
  endtask

  // Advance one edge and compare the bus against the oldest expectation
  task automatic cyc(input string name);
    exp_t e;
    tick();
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s observed=bus expected=queued-entry (queue empty)", name);
    end else begin
      e = exp_q.pop_front();
      chk({name, ".t0"}, 32'(cdb_out.t0), 32'(e.t0));
      chk({name, ".t1"}, 32'(cdb_out.t1), 32'(e.t1));
      chk({name, ".t2"}, 32'(cdb_out.t2), 32'(e.t2));
      chk({name, ".d0"}, wr_data[0], e.d0);
      chk({name, ".d1"}, wr_data[1], e.d1);
      chk({name, ".d2"}, wr_data[2], e.d2);
      chk({name, ".cnt"}, 32'(cdb_count), 32'(e.cnt));
    end
  endtask

  initial begin
    reset    = 1'b1;
    squash   = 1'b0;
    fu_valid = '0;
    fu_tag   = '0;
    fu_data  = '0;

    // Reset state
    tick();
    tick();
    chk("rst.cdb_out", 32'(cdb_out), 32'h0);
    chk("rst.wr0", wr_data[0], 32'h0);
    chk("rst.wr1", wr_data[1], 32'h0);
    chk("rst.wr2", wr_data[2], 32'h0);
    chk("rst.count", 32'(cdb_count), 32'h0);
    chk("rst.ready", 32'(fu_ready), 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_rel.ready", 32'(fu_ready), 32'h3f);

    // Single result: two edges from transfer to bus
    send(2, 6'd9, 32'h1234);
    push_idle();
    cyc("single_e1");
    drop(2);
    push_exp(6'd9, ZERO_PR, ZERO_PR, 32'h1234, '0, '0, 2'd1);
    cyc("single_e2");
    push_idle();
    cyc("single_e3");

    // Fresh pointer before oversubscription
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Oversubscription: six results, three per cycle, lowest index first
    for (int i = 0; i < 6; i++) send(i, PR'(i + 1), 32'h100 + 32'(i + 1));
    push_idle();
    cyc("over_e1");
    chk("over.ready_e1", 32'(fu_ready), 32'h07);
    for (int i = 0; i < 6; i++) drop(i);
    push_exp(6'd1, 6'd2, 6'd3, 32'h101, 32'h102, 32'h103, 2'd3);
    cyc("over_e2");
    chk("over.ready_e2", 32'(fu_ready), 32'h3f);
    push_exp(6'd4, 6'd5, 6'd6, 32'h104, 32'h105, 32'h106, 2'd3);
    cyc("over_e3");
    push_idle();
    cyc("over_e4");

    // Backpressure: FU3 holds a second result while its slot waits
    send(0, 6'd10, 32'hA10);
    send(1, 6'd11, 32'hA11);
    send(2, 6'd12, 32'hA12);
    send(3, 6'd13, 32'hD13);
    push_idle();
    cyc("bp_e1");
    send(3, 6'd14, 32'hD14);
    chk("bp.ready3_e1", 32'(fu_ready[3]), 32'h0);
`ifdef CDB_RR_PRIORITY_EN
    push_exp(6'd10, 6'd11, 6'd12, 32'hA10, 32'hA11, 32'hA12, 2'd3);
    cyc("bp_e2");
    chk("bp.ready3_e2", 32'(fu_ready[3]), 32'h1);
    drop(0); drop(1); drop(2);
    push_exp(6'd13, 6'd10, 6'd11, 32'hD13, 32'hA10, 32'hA11, 2'd3);
    cyc("bp_e3");
    drop(3);
    push_exp(6'd12, 6'd14, ZERO_PR, 32'hA12, 32'hD14, '0, 2'd2);
    cyc("bp_e4");
    push_idle();
    cyc("bp_e5");
`else
    push_exp(6'd10, 6'd11, 6'd12, 32'hA10, 32'hA11, 32'hA12, 2'd3);
    cyc("bp_e2");
    chk("bp.ready3_e2", 32'(fu_ready[3]), 32'h0);
    push_exp(6'd10, 6'd11, 6'd12, 32'hA10, 32'hA11, 32'hA12, 2'd3);
    cyc("bp_e3");
    drop(0); drop(1); drop(2);
    chk("bp.ready3_e3", 32'(fu_ready[3]), 32'h0);
    push_exp(6'd10, 6'd11, 6'd12, 32'hA10, 32'hA11, 32'hA12, 2'd3);
    cyc("bp_e4");
    chk("bp.ready3_e4", 32'(fu_ready[3]), 32'h1);
    push_exp(6'd13, ZERO_PR, ZERO_PR, 32'hD13, '0, '0, 2'd1);
    cyc("bp_e5");
    drop(3);
    push_exp(6'd14, ZERO_PR, ZERO_PR, 32'hD14, '0, '0, 2'd1);
    cyc("bp_e6");
    push_idle();
    cyc("bp_e7");
`endif

    // Zero tag: accepted every cycle, never broadcast
    send(1, ZERO_PR, 32'hFFFF);
    for (int n = 0; n < 3; n++) begin
      chk("zero.ready1", 32'(fu_ready[1]), 32'h1);
      push_idle();
      cyc("zero");
    end
    drop(1);
    push_idle();
    cyc("zero_tail");

    // Squash with five full slots
    for (int i = 0; i < 5; i++) send(i, PR'(20 + i), 32'h200 + 32'(i));
    push_idle();
    cyc("sq_fill");
    for (int i = 0; i < 5; i++) drop(i);
    squash = 1'b1;
    push_idle();
    cyc("sq_k");
    squash = 1'b0;
    send(5, 6'd30, 32'h3030);
    push_idle();
    cyc("sq_k1");
    drop(5);
    push_exp(6'd30, ZERO_PR, ZERO_PR, 32'h3030, '0, '0, 2'd1);
    cyc("sq_k2");
    push_idle();
    cyc("sq_k3");
    push_idle();
    cyc("sq_k4");

    // Mid-operation reset with three full slots
    send(0, 6'd40, 32'h40);
    send(1, 6'd41, 32'h41);
    send(2, 6'd42, 32'h42);
    push_idle();
    cyc("mr_fill");
    for (int i = 0; i < 3; i++) drop(i);
    reset = 1'b1;
    #1;
    chk("mr.ready_a", 32'(fu_ready), 32'h0);
    push_idle();
    cyc("mr_r1");
    chk("mr.ready_b", 32'(fu_ready), 32'h0);
    push_idle();
    cyc("mr_r2");
    reset = 1'b0;
    #1;
    chk("mr.ready_rel", 32'(fu_ready), 32'h3f);
    push_idle();
    cyc("mr_post1");
    push_idle();
    cyc("mr_post2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
